// File: rtl/stream_pkg.sv
// Shared types and constants for the data_distributor packet router.
// Covers the FSM state enum, the tuple payload shape and the drop counter width.
package stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } distributor_state_t;

    localparam int DROP_CNT_WIDTH = 16;

    localparam int NUM_TUPLES  = 2;
    localparam int TUPLE_WIDTH = 8;

    typedef logic [TUPLE_WIDTH-1:0] tuple_t;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (v == {DROP_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/data_distributor_if.sv
// Handshake interfaces used by data_distributor: a plain ready/valid token
// stream and the ndata packet stream (data, keep, last, valid, ready).
interface ready_valid_i #(
    parameter int WIDTH = 1
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport m (output data, output valid, input ready);
    modport s (input data, input valid, output ready);
endinterface

interface ndata_i import stream_pkg::*; ();
    tuple_t [NUM_TUPLES-1:0] data;
    logic   [NUM_TUPLES-1:0] keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport m (output data, output keep, output last, output valid, input ready);
    modport s (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/data_distributor_out_reg.sv
// One-entry ndata pipeline register: loads a beat, holds it while stalled and
// clears its valid once the selected consumer takes it.
module ndata_out_reg import stream_pkg::*; (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    drain_ready,
    input  tuple_t [NUM_TUPLES-1:0] data_i,
    input  logic   [NUM_TUPLES-1:0] keep_i,
    input  logic                    last_i,
    output logic                    valid_q,
    output tuple_t [NUM_TUPLES-1:0] data_q,
    output logic   [NUM_TUPLES-1:0] keep_q,
    output logic                    last_q
);

    logic                    valid_d;
    tuple_t [NUM_TUPLES-1:0] data_d;
    logic   [NUM_TUPLES-1:0] keep_d;
    logic                    last_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        valid_d = valid_q & ~drain_ready;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
        end
    end

    // NOTE: the payload is reset too, so nothing stale is visible after rst_n releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/data_distributor.sv
// Packet-granular 1-to-N router: one select token steers one whole packet.
// Define DATA_DISTRIBUTOR_DROP_INVALID_EN to discard packets with an out-of-range index.
module data_distributor import stream_pkg::*; #(
    parameter int NUM_STREAMS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ready_valid_i.s                   select,
    ndata_i.s                         in,
    ndata_i.m                         out [NUM_STREAMS]
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

    localparam int SEL_WIDTH = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int SEL_SPAN  = 1 << SEL_WIDTH;

    distributor_state_t state_q, state_d;
    logic                 sel_ready_q, sel_ready_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] out_sel_q, out_sel_d;
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
    logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
`endif

    logic [SEL_WIDTH-1:0]    sel_raw, sel_clamped;
    logic                    sel_in_range, sel_fire, in_fire, in_ready, load;
    logic [SEL_SPAN-1:0]     out_ready_vec;
    logic                    drain_ready;
    logic                    out_valid_q;
    tuple_t [NUM_TUPLES-1:0] data_q;
    logic   [NUM_TUPLES-1:0] keep_q;
    logic                    last_q;

    assign sel_raw      = select.data;
    assign sel_in_range = (int'(sel_raw) < NUM_STREAMS);
    assign sel_clamped  = sel_in_range ? sel_raw : SEL_WIDTH'(NUM_STREAMS - 1);
    assign sel_fire     = sel_ready_q & select.valid;

    // The register always drains toward its own target, which may still be
    // the previous packet's destination while the next packet is routing.
    assign drain_ready = out_ready_vec[out_sel_q];

    always_comb begin
        in_ready = 1'b0;
        if (state_q == ROUTE) in_ready = ~out_valid_q | drain_ready;
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
        if (state_q == DROP) in_ready = 1'b1;
`endif
    end

    assign in_fire   = in.valid & in_ready;
    assign load      = in_fire & (state_q == ROUTE);
    assign out_sel_d = load ? sel_q : out_sel_q;

    assign select.ready = sel_ready_q;
    assign in.ready     = in_ready;

    always_comb begin
        state_d     = state_q;
        sel_ready_d = sel_ready_q;
        sel_d       = sel_q;
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
        drop_count_d = drop_count_q;
`endif
        unique case (state_q)
            IDLE: begin
                sel_ready_d = 1'b1;
                if (sel_fire) begin
                    sel_ready_d = 1'b0;
                    sel_d       = sel_clamped;
                    state_d     = ROUTE;
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
                    if (!sel_in_range) state_d = DROP;
`endif
                end
            end
            ROUTE: begin
                if (in_fire && in.last) begin
                    state_d     = IDLE;
                    sel_ready_d = 1'b1;
                end
            end
            DROP: begin
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
                if (in_fire && in.last) begin
                    state_d      = IDLE;
                    sel_ready_d  = 1'b1;
                    drop_count_d = sat_inc(drop_count_q);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_ready_q <= 1'b0;
            sel_q       <= '0;
            out_sel_q   <= '0;
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
            drop_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_ready_q <= sel_ready_d;
            sel_q       <= sel_d;
            out_sel_q   <= out_sel_d;
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
            drop_count_q <= drop_count_d;
`endif
        end
    end

`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
    assign drop_count = drop_count_q;
`endif

    ndata_out_reg u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .drain_ready (drain_ready),
        .data_i      (in.data),
        .keep_i      (in.keep),
        .last_i      (in.last),
        .valid_q     (out_valid_q),
        .data_q      (data_q),
        .keep_q      (keep_q),
        .last_q      (last_q)
    );

    // Payload is broadcast; only valid is steered to the registered target.
    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_out
        assign out[g].data    = data_q;
        assign out[g].keep    = keep_q;
        assign out[g].last    = last_q;
        assign out[g].valid   = out_valid_q & (out_sel_q == SEL_WIDTH'(g));
        assign out_ready_vec[g] = out[g].ready;
    end

    if (SEL_SPAN > NUM_STREAMS) begin : g_ready_pad
        assign out_ready_vec[SEL_SPAN-1:NUM_STREAMS] = '0;
    end

endmodule

// File: tb/tb_data_distributor.sv
// Scoreboard bench for data_distributor with three outputs, so index 3 is out of range.
// Expected beats come from a packet-level routing model; a negedge monitor checks outputs.
module tb_data_distributor;
    import stream_pkg::*;

    localparam int NS     = 3;
    localparam int SW     = 2;
    localparam int DW     = NUM_TUPLES * TUPLE_WIDTH;
    localparam int KW     = NUM_TUPLES;
    localparam int BUDGET = 200;

    typedef struct {
        int            stream;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            in_cyc;
    } beat_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] rdy   = '1;
    bit            rand_rdy  = 1'b0;
    bit            lat_chk   = 1'b0;
    bit            sel_noise = 1'b0;
    int            cyc      = 0;
    int            checks   = 0;
    int            failures = 0;
    int            drop_cnt = 0;
    beat_t         exp_q[$];
    int            in_hs[$];

    ready_valid_i #(.WIDTH(SW)) sel_if ();
    ndata_i                     in_if ();
    ndata_i                     out_if [NS] ();

    logic [NS-1:0] mon_valid;
    logic [DW-1:0] mon_data [NS];
    logic [KW-1:0] mon_keep [NS];
    logic          mon_last [NS];
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
    logic [DROP_CNT_WIDTH-1:0] drop_count;
`endif

    data_distributor #(.NUM_STREAMS(NS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .select (sel_if),
        .in     (in_if),
        .out    (out_if)
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
        ,
        .drop_count (drop_count)
`endif
    );

    for (genvar g = 0; g < NS; g++) begin : g_mon
        assign out_if[g].ready = rdy[g];
        assign mon_valid[g]    = out_if[g].valid;
        assign mon_data[g]     = out_if[g].data;
        assign mon_keep[g]     = out_if[g].keep;
        assign mon_last[g]     = out_if[g].last;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            for (int i = 0; i < NS; i++) rdy[i] = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference routing rule: in-range index routes directly; otherwise the
    // packet is dropped (feature) or goes to the last stream.
    function automatic int dest_of(input int sel);
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
        if (sel >= NS) return -1;
`endif
        return (sel >= NS) ? NS - 1 : sel;
    endfunction

    // Monitor: pops one expected beat per output transfer and checks stall hold.
    bit            prev_stall = 1'b0;
    int            prev_s = 0;
    logic [DW-1:0] prev_d;
    logic [KW-1:0] prev_k;
    logic          prev_l;
    int            mon_nv;
    beat_t         mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_nv = 0;
            for (int g = 0; g < NS; g++) if (mon_valid[g]) mon_nv++;
            if (mon_nv > 1) check("onehot_valid", 64'(mon_nv), 64'd1);
            if (prev_stall)
                check("stall_hold", {mon_valid[prev_s], mon_data[prev_s], mon_keep[prev_s], mon_last[prev_s]},
                      {1'b1, prev_d, prev_k, prev_l});
            prev_stall = 1'b0;
            for (int g = 0; g < NS; g++) begin
                if (mon_valid[g]) begin
                    if (rdy[g]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL spurious_beat: stream=%0d data=%0h, required no beat, cycle=%0d",
                                     g, mon_data[g], cyc);
                        end else begin
                            mon_e = exp_q.pop_front();
                            check("beat_stream", 64'(g), 64'(mon_e.stream));
                            check("beat_payload", {mon_data[g], mon_keep[g], mon_last[g]},
                                  {mon_e.data, mon_e.keep, mon_e.last});
                            if (lat_chk) check("latency", 64'(cyc - mon_e.in_cyc), 64'd1);
                        end
                    end else begin
                        prev_stall = 1'b1;
                        prev_s = g;
                        prev_d = mon_data[g];
                        prev_k = mon_keep[g];
                        prev_l = mon_last[g];
                    end
                end
            end
        end
    end

    task automatic wait_sel(output int hc);
        int n;
        n  = 0;
        hc = -1;
        while (hc < 0) begin
            @(negedge clk);
            if (sel_if.valid && sel_if.ready) hc = cyc;
            else if (++n > BUDGET) begin
                checks++;
                failures++;
                $display("FAIL sel_timeout: no select handshake within %0d cycles", BUDGET);
                hc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in(output int hc);
        int n;
        n  = 0;
        hc = -1;
        while (hc < 0) begin
            @(negedge clk);
            check("sel_ready_in_packet", 64'(sel_if.ready), 64'd0);
            if (in_if.valid && in_if.ready) hc = cyc;
            else if (++n > BUDGET) begin
                checks++;
                failures++;
                $display("FAIL in_timeout: no input handshake within %0d cycles", BUDGET);
                hc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
    task automatic send_packet(input int sel, input int nbeats);
        int    hc;
        int    dest;
        beat_t e;
        dest = dest_of(sel);
        in_if.valid  = 1'b0;
        sel_if.valid = 1'b1;
        sel_if.data  = SW'(sel);
        wait_sel(hc);
        sel_if.valid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            in_if.valid = 1'b1;
            in_if.data  = DW'($urandom);
            in_if.keep  = KW'($urandom_range(1, 3));
            in_if.last  = (b == nbeats - 1);
            if (sel_noise) begin
                sel_if.valid = 1'($urandom);
                sel_if.data  = SW'($urandom);
            end
            wait_in(hc);
            in_hs.push_back(hc);
            if (dest >= 0) begin
                e.stream = dest;
                e.data   = in_if.data;
                e.keep   = in_if.keep;
                e.last   = in_if.last;
                e.in_cyc = hc;
                exp_q.push_back(e);
            end
        end
        in_if.valid  = 1'b0;
        in_if.last   = 1'b0;
        sel_if.valid = 1'b0;
        if (dest < 0 && drop_cnt < 65535) drop_cnt++;
        check("sel_ready_after_last", 64'(sel_if.ready), 64'd1);
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
        check("drop_count", 64'(drop_count), 64'(drop_cnt));
`endif
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rdy = '1;
        while (exp_q.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic reset_mid_packet();
        int hc;
        rdy = '0;
        sel_if.valid = 1'b1;
        sel_if.data  = SW'(1);
        wait_sel(hc);
        sel_if.valid = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = DW'($urandom);
        in_if.keep  = '1;
        in_if.last  = 1'b0;
        wait_in(hc);
        in_if.data = DW'($urandom);
        @(negedge clk);
        check("rst_pre_in_blocked", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_if.valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(mon_valid), 64'd0);
        check("rst_sel_ready", 64'(sel_if.ready), 64'd0);
        check("rst_in_ready", 64'(in_if.ready), 64'd0);
        exp_q.delete();
        drop_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy = '1;
        @(negedge clk);
        check("rst_release_sel_ready_early", 64'(sel_if.ready), 64'd0);
        @(negedge clk);
        check("rst_release_sel_ready", 64'(sel_if.ready), 64'd1);
        repeat (4) @(negedge clk);
        check("rst_no_stale_valid", 64'(mon_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel_if.valid = 1'b0;
        sel_if.data  = '0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.keep   = '0;
        in_if.last   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(mon_valid), 64'd0);
        check("reset_sel_ready", 64'(sel_if.ready), 64'd0);
        check("reset_in_ready", 64'(in_if.ready), 64'd0);
`ifdef DATA_DISTRIBUTOR_DROP_INVALID_EN
        check("reset_drop_count", 64'(drop_count), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("release_sel_ready_early", 64'(sel_if.ready), 64'd0);
        @(negedge clk);
        check("release_sel_ready", 64'(sel_if.ready), 64'd1);
        in_if.valid = 1'b1;
        @(negedge clk);
        check("idle_in_not_ready", 64'(in_if.ready), 64'd0);
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;

        // Basic 3-beat route to stream 2 with all readies high.
        lat_chk = 1'b1;
        in_hs.delete();
        send_packet(2, 3);
        check("basic_beats_consecutive", 64'(in_hs[2] - in_hs[0]), 64'd2);
        wait_drain();

        // Single-beat packets: two cycles per packet, index 3 exercises out-of-range.
        in_hs.delete();
        for (int s = 0; s < 4; s++) send_packet(s, 1);
        check("single_beat_spacing", 64'(in_hs[3] - in_hs[0]), 64'd6);
        wait_drain();
        lat_chk = 1'b0;

        // Backpressure on stream 1 for five cycles mid-packet.
        fork
            send_packet(1, 4);
            begin
                repeat (3) @(posedge clk);
                #1 rdy = 3'b101;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_blocked", 64'(in_if.ready), 64'd0);
                end
                @(posedge clk);
                #1 rdy = '1;
            end
        join
        wait_drain();

        // Back-to-back: A's last stalls on stream 0 while B waits for the register.
        fork
            begin
                send_packet(0, 2);
                send_packet(2, 1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 rdy = 3'b110;
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("b2b_in_blocked", 64'(in_if.ready), 64'd0);
                end
                @(posedge clk);
                #1 rdy = '1;
            end
        join
        wait_drain();

        // Out-of-range index with a 4-beat packet: dropped or clamped to stream 2.
        in_hs.delete();
        send_packet(3, 4);
        check("oor_beats_consecutive", 64'(in_hs[3] - in_hs[0]), 64'd3);
        wait_drain();

        reset_mid_packet();

        // Randomized traffic with random downstream readies and select noise.
        rand_rdy  = 1'b1;
        sel_noise = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int k = 0; k < gap; k++) begin
                in_if.valid = 1'($urandom);
                @(negedge clk);
                if (in_if.valid) check("idle_in_ignored", 64'(in_if.ready), 64'd0);
                @(posedge clk);
                #1;
            end
            send_packet($urandom_range(0, 3), $urandom_range(1, 4));
        end
        sel_noise = 1'b0;
        rand_rdy  = 1'b0;
        @(posedge clk);
        #2;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
